// File: rtl/alu_result_mux.sv
// Registered N:1 ALU result multiplexer with per-channel valid/ready handshake.
// Grants by direct select (mode=0) or round-robin after the last grant (mode=1).
module alu_result_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_zero,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_zero;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic                w_xfer;
    logic                w_dir_vld;
    logic [CHANNELS-1:0] w_hi_req;
    logic [SEL_W:0]      w_hi_pick;
    logic [SEL_W:0]      w_lo_pick;
    logic [SEL_W:0]      w_rr_pick;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]    w_grant_data;
    logic [CHANNELS-1:0] w_in_ready;

    // Lowest set bit of a request vector, returned as {found, index}.
    function automatic logic [SEL_W:0] first_set(input logic [CHANNELS-1:0] v);
        logic [SEL_W:0] r;
        r = {(SEL_W + 1){1'b0}};
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = {1'b1, SEL_W'(k)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] d);
        return (d == {WIDTH{1'b0}});
    endfunction

    assign w_load_en = !r_out_valid || out_ready;

    // Direct select: an index beyond the last channel never grants.
    always_comb begin
        if (int'(sel) < CHANNELS) begin
            w_dir_vld = in_valid[sel];
        end else begin
            w_dir_vld = 1'b0;
        end
    end

    // Round-robin: channels above r_ptr win first, otherwise wrap to the lowest valid.
    always_comb begin
        w_hi_req = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            w_hi_req[k] = in_valid[k] && (SEL_W'(k) > r_ptr);
        end
        w_hi_pick = first_set(w_hi_req);
        w_lo_pick = first_set(in_valid);
        if (w_hi_pick[SEL_W]) begin
            w_rr_pick = w_hi_pick;
        end else begin
            w_rr_pick = w_lo_pick;
        end
    end

    // Grant selection, data mux and one-hot ready.
    always_comb begin
        if (mode) begin
            w_grant_vld = w_rr_pick[SEL_W];
            w_grant_idx = w_rr_pick[SEL_W-1:0];
        end else begin
            w_grant_vld = w_dir_vld;
            w_grant_idx = sel;
        end
        w_xfer       = w_grant_vld && w_load_en && !rst;
        w_grant_data = {WIDTH{1'b0}};
        w_in_ready   = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            w_grant_data = w_grant_data
                         | (in_data[k*WIDTH +: WIDTH] & {WIDTH{w_grant_idx == SEL_W'(k)}});
            w_in_ready[k] = w_xfer && (w_grant_idx == SEL_W'(k));
        end
    end

    // Output word register and round-robin pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= {WIDTH{1'b0}};
            r_out_chan  <= {SEL_W{1'b0}};
            r_out_zero  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ptr       <= PTR_RST;
        end else if (w_load_en) begin
            if (w_grant_vld) begin
                r_out_data  <= w_grant_data;
                r_out_chan  <= w_grant_idx;
                r_out_zero  <= is_zero(w_grant_data);
                r_out_valid <= 1'b1;
                r_ptr       <= mode ? w_grant_idx : r_ptr;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_zero  = r_out_zero;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_result_mux.sv
// Bench for alu_result_mux: an 8-channel and a 6-channel instance driven by directed
// and random stimulus, checked against a behavioural grant/output-word model.
`timescale 1ns/1ps
module tb_alu_result_mux;

    localparam int NU = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nch [NU] = '{8, 6};
    int n_tests;
    int n_fail;

    logic         drv_rst;
    logic [255:0] drv_data   [NU];
    logic [15:0]  drv_valid  [NU];
    logic         drv_mode   [NU];
    logic [2:0]   drv_sel    [NU];
    logic         drv_oready [NU];

    logic [7:0]  a_in_ready;
    logic [15:0] a_out_data;
    logic [2:0]  a_out_chan;
    logic        a_out_zero;
    logic        a_out_valid;
    logic [5:0]  b_in_ready;
    logic [15:0] b_out_data;
    logic [2:0]  b_out_chan;
    logic        b_out_zero;
    logic        b_out_valid;

    alu_result_mux #(.WIDTH(16), .CHANNELS(8)) u_dut8 (
        .clk(clk), .rst(drv_rst),
        .in_data(drv_data[0][127:0]), .in_valid(drv_valid[0][7:0]), .in_ready(a_in_ready),
        .mode(drv_mode[0]), .sel(drv_sel[0]),
        .out_data(a_out_data), .out_chan(a_out_chan), .out_zero(a_out_zero),
        .out_valid(a_out_valid), .out_ready(drv_oready[0])
    );

    alu_result_mux #(.WIDTH(16), .CHANNELS(6)) u_dut6 (
        .clk(clk), .rst(drv_rst),
        .in_data(drv_data[1][95:0]), .in_valid(drv_valid[1][5:0]), .in_ready(b_in_ready),
        .mode(drv_mode[1]), .sel(drv_sel[1]),
        .out_data(b_out_data), .out_chan(b_out_chan), .out_zero(b_out_zero),
        .out_valid(b_out_valid), .out_ready(drv_oready[1])
    );

    logic [15:0] obs_ready [NU];
    logic [15:0] obs_data  [NU];
    logic [2:0]  obs_chan  [NU];
    logic        obs_zero  [NU];
    logic        obs_valid [NU];
    assign obs_ready[0] = {8'h00, a_in_ready};
    assign obs_ready[1] = {10'h000, b_in_ready};
    assign obs_data[0]  = a_out_data;
    assign obs_data[1]  = b_out_data;
    assign obs_chan[0]  = a_out_chan;
    assign obs_chan[1]  = b_out_chan;
    assign obs_zero[0]  = a_out_zero;
    assign obs_zero[1]  = b_out_zero;
    assign obs_valid[0] = a_out_valid;
    assign obs_valid[1] = b_out_valid;

    // Reference model state: the word the output register should present.
    logic        m_valid [NU];
    logic [15:0] m_data  [NU];
    int          m_chan  [NU];
    logic        m_zero  [NU];
    int          m_last  [NU];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel that should be granted, or -1 when none.
    function automatic int pick(input int n, input logic md, input int s,
                                input logic [15:0] v, input int last);
        int c;
        if (!md) begin
            if (s < n && v[s]) return s;
            return -1;
        end
        for (int step = 1; step <= n; step++) begin
            c = (last + step) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset(input int u);
        m_valid[u] = 1'b0;
        m_data[u]  = 16'h0000;
        m_chan[u]  = 0;
        m_zero[u]  = 1'b1;
        m_last[u]  = nch[u] - 1;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        int          g [NU];
        logic        ld [NU];
        logic [15:0] er;
        for (int u = 0; u < NU; u++) begin
            g[u]  = pick(nch[u], drv_mode[u], int'(drv_sel[u]),
                         drv_valid[u] & ((16'd1 << nch[u]) - 16'd1), m_last[u]);
            ld[u] = !m_valid[u] || drv_oready[u];
        end
        #1;
        for (int u = 0; u < NU; u++) begin
            er = 16'h0000;
            if (!drv_rst && ld[u] && g[u] >= 0) er = 16'd1 << g[u];
            check_eq($sformatf("u%0d_in_ready", u), {16'h0000, obs_ready[u]}, {16'h0000, er});
        end
        @(posedge clk);
        for (int u = 0; u < NU; u++) begin
            if (drv_rst) begin
                model_reset(u);
            end else if (ld[u]) begin
                if (g[u] >= 0) begin
                    m_data[u]  = drv_data[u][g[u]*16 +: 16];
                    m_chan[u]  = g[u];
                    m_zero[u]  = (m_data[u] == 16'h0000);
                    m_valid[u] = 1'b1;
                    if (drv_mode[u]) m_last[u] = g[u];
                end else begin
                    m_valid[u] = 1'b0;
                end
            end
        end
        #1;
        for (int u = 0; u < NU; u++) begin
            check_eq($sformatf("u%0d_out_valid", u), 32'(obs_valid[u]), 32'(m_valid[u]));
            check_eq($sformatf("u%0d_out_data", u), 32'(obs_data[u]), 32'(m_data[u]));
            check_eq($sformatf("u%0d_out_chan", u), 32'(obs_chan[u]), 32'(m_chan[u]));
            check_eq($sformatf("u%0d_out_zero", u), 32'(obs_zero[u]), 32'(m_zero[u]));
        end
    endtask

    task automatic set_chan_data(input int u, input int k, input logic [15:0] d);
        drv_data[u][k*16 +: 16] = d;
    endtask

    int          exp_seq [6] = '{0, 2, 7, 0, 2, 7};
    logic [31:0] rnd_word;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int u = 0; u < NU; u++) begin
            drv_data[u]   = '0;
            drv_valid[u]  = (16'd1 << nch[u]) - 16'd1;
            drv_mode[u]   = 1'b0;
            drv_sel[u]    = 3'd0;
            drv_oready[u] = 1'b1;
            model_reset(u);
        end

        // Reset held two cycles with every channel valid
        drv_rst = 1'b1;
        tick();
        tick();
        check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_out_data", 32'(a_out_data), 32'd0);
        check_eq("rst_out_zero", 32'(a_out_zero), 32'd1);
        check_eq("rst_in_ready", 32'(a_in_ready), 32'd0);

        // First round-robin grant is channel 0, then a fair rotation
        drv_rst     = 1'b0;
        drv_mode[0] = 1'b1;
        for (int k = 0; k < 8; k++) set_chan_data(0, k, 16'h2000 + 16'(k));
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("rr_fair_chan", 32'(a_out_chan), 32'(i % 8));
        end

        // Direct select sweep
        drv_mode[0] = 1'b0;
        for (int k = 0; k < 8; k++) set_chan_data(0, k, 16'h1000 + 16'(k));
        for (int s = 0; s < 8; s++) begin
            drv_sel[0] = 3'(s);
            tick();
            check_eq("sweep_data", 32'(a_out_data), 32'h1000 + 32'(s));
            check_eq("sweep_chan", 32'(a_out_chan), 32'(s));
        end

        // Round-robin with wrap over a sparse valid set
        drv_rst = 1'b1;
        tick();
        drv_rst      = 1'b0;
        drv_mode[0]  = 1'b1;
        drv_valid[0] = 16'h0085;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("rr_wrap_chan", 32'(a_out_chan), 32'(exp_seq[i]));
        end

        // Downstream stall holds the word; release pops and accepts together
        drv_mode[0]  = 1'b0;
        drv_sel[0]   = 3'd3;
        drv_valid[0] = 16'h00FF;
        set_chan_data(0, 3, 16'hBEEF);
        tick();
        drv_oready[0] = 1'b0;
        set_chan_data(0, 3, 16'hCAFE);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stall_data", 32'(a_out_data), 32'h0000BEEF);
            check_eq("stall_valid", 32'(a_out_valid), 32'd1);
            check_eq("stall_ready", 32'(a_in_ready), 32'd0);
        end
        drv_oready[0] = 1'b1;
        tick();
        check_eq("unstall_data", 32'(a_out_data), 32'h0000CAFE);

        // Six-channel instance: out-of-range select, then a zero word
        for (int k = 0; k < 6; k++) set_chan_data(1, k, 16'h0A00 + 16'(k));
        drv_sel[1] = 3'd1;
        tick();
        check_eq("b_pre_valid", 32'(b_out_valid), 32'd1);
        drv_sel[1] = 3'd7;
        tick();
        check_eq("badsel_valid", 32'(b_out_valid), 32'd0);
        drv_sel[1] = 3'd2;
        set_chan_data(1, 2, 16'h0000);
        tick();
        check_eq("zero_flag", 32'(b_out_zero), 32'd1);
        check_eq("zero_chan", 32'(b_out_chan), 32'd2);

        // Reset during a downstream stall discards the held word
        drv_sel[0] = 3'd5;
        tick();
        drv_oready[0] = 1'b0;
        tick();
        check_eq("midrst_pre_valid", 32'(a_out_valid), 32'd1);
        drv_rst = 1'b1;
        tick();
        check_eq("midrst_valid", 32'(a_out_valid), 32'd0);
        drv_rst       = 1'b0;
        drv_oready[0] = 1'b1;
        drv_valid[0]  = 16'h0000;
        tick();
        check_eq("midrst_gone", 32'(a_out_valid), 32'd0);

        // Random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            drv_rst = ($urandom_range(63) == 0);
            for (int u = 0; u < NU; u++) begin
                for (int w = 0; w < 8; w++) begin
                    rnd_word = $urandom;
                    drv_data[u][w*32 +: 32] = rnd_word;
                end
                for (int k = 0; k < 16; k++) begin
                    if ($urandom_range(7) == 0) set_chan_data(u, k, 16'h0000);
                end
                drv_valid[u]  = 16'($urandom) & ((16'd1 << nch[u]) - 16'd1);
                if ($urandom_range(15) == 0) drv_mode[u] = ~drv_mode[u];
                drv_sel[u]    = 3'($urandom_range(7));
                drv_oready[u] = ($urandom_range(3) != 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
